// File: rtl/rsa_mont_exp_ctrl.sv
// rtl/rsa_mont_exp_ctrl.sv - LSB-first square-and-multiply sequencer driving one shared Montgomery multiplier
module rsa_mont_exp_ctrl #(
  parameter int MOD_WIDTH = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base,
  input  logic [EXP_WIDTH-1:0] i_exponent,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_one,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [MOD_WIDTH-1:0] r_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_result
);
  localparam int CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CNT_W:0] LAST = (CNT_W+1)'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ISSUE_MUL, WAIT_MUL, ISSUE_SQR, WAIT_SQR, DONE} state_t;

  state_t               state;
  logic [MOD_WIDTH-1:0] acc, base, mod;
  logic [EXP_WIDTH-1:0] expo, expo_shift;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W:0]       cnt_nxt;
  logic                 bit_nxt;

  // Exponent bit that will be processed once the current square lands.
  always_comb begin
    cnt_nxt    = {1'b0, cnt} + (CNT_W+1)'(1);
    expo_shift = expo >> cnt_nxt;
    bit_nxt    = expo_shift[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      base      <= '0;
      expo      <= '0;
      mod       <= '0;
      cnt       <= '0;
      i_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_a       <= '0;
      m_b       <= '0;
      m_modulus <= '0;
      r_ready   <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            acc       <= i_one;
            base      <= i_base;
            expo      <= i_exponent;
            mod       <= i_modulus;
            cnt       <= '0;
            i_ready   <= 1'b0;
            m_modulus <= i_modulus;
            if (i_exponent[0]) begin
              state   <= ISSUE_MUL;
              m_valid <= 1'b1;
              m_a     <= i_one;
              m_b     <= i_base;
            end else if (EXP_WIDTH == 1) begin
              state    <= DONE;
              o_valid  <= 1'b1;
              o_result <= i_one;
            end else begin
              state   <= ISSUE_SQR;
              m_valid <= 1'b1;
              m_a     <= i_base;
              m_b     <= i_base;
            end
          end
        end
        ISSUE_MUL, ISSUE_SQR: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            r_ready <= 1'b1;
            state   <= (state == ISSUE_MUL) ? WAIT_MUL : WAIT_SQR;
          end
        end
        WAIT_MUL: begin
          if (r_valid) begin
            acc     <= r_data;
            r_ready <= 1'b0;
            if ({1'b0, cnt} < LAST) begin
              state   <= ISSUE_SQR;
              m_valid <= 1'b1;
              m_a     <= base;
              m_b     <= base;
            end else begin
              state    <= DONE;
              o_valid  <= 1'b1;
              o_result <= r_data;
            end
          end
        end
        WAIT_SQR: begin
          if (r_valid) begin
            base    <= r_data;
            cnt     <= cnt_nxt[CNT_W-1:0];
            r_ready <= 1'b0;
            if (bit_nxt) begin
              state   <= ISSUE_MUL;
              m_valid <= 1'b1;
              m_a     <= acc;
              m_b     <= r_data;
            end else if (cnt_nxt < LAST) begin
              state   <= ISSUE_SQR;
              m_valid <= 1'b1;
              m_a     <= r_data;
              m_b     <= r_data;
            end else begin
              state    <= DONE;
              o_valid  <= 1'b1;
              o_result <= acc;
            end
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_mont_exp_ctrl.sv
// tb/tb_rsa_mont_exp_ctrl.sv - directed bench for rsa_mont_exp_ctrl with a behavioural Montgomery multiplier (R=256)
module tb_rsa_mont_exp_ctrl;
  localparam int MW = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [MW-1:0] i_base = '0;
  logic [EW-1:0] i_exponent = '0;
  logic [MW-1:0] i_modulus = '0;
  logic [MW-1:0] i_one = '0;
  logic          m_valid;
  logic          m_ready;
  logic [MW-1:0] m_a, m_b, m_modulus;
  logic          r_valid;
  logic          r_ready;
  logic [MW-1:0] r_data;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [MW-1:0] o_result;

  rsa_mont_exp_ctrl #(.MOD_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_base(i_base), .i_exponent(i_exponent),
    .i_modulus(i_modulus), .i_one(i_one),
    .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_b(m_b), .m_modulus(m_modulus),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_result(o_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hold_cycles = 0;
  int dly_min = 0;
  int dly_max = 0;
  bit spur_en = 1'b0;
  logic [MW-1:0] log_a[$], log_b[$], log_m[$];

  // a*b*R^-1 mod n, found by searching for r with r*R == a*b (mod n)
  function automatic logic [MW-1:0] mont(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] n);
    int p;
    p = (int'(a) * int'(b)) % int'(n);
    for (int r = 0; r < int'(n); r++)
      if ((r * 256) % int'(n) == p) return MW'(r);
    return '0;
  endfunction

  // Behavioural multiplier: configurable request backpressure, response delay and spurious r_valid.
  initial begin : multiplier
    logic [MW-1:0] res, hold_a, hold_b;
    bit busy, m_fire, r_fire, was_req;
    int hold, dly;
    m_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    res = '0; hold_a = '0; hold_b = '0;
    busy = 0; m_fire = 0; r_fire = 0; was_req = 0; hold = 0; dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ready = 1'b0; r_valid = 1'b0;
        busy = 0; m_fire = 0; r_fire = 0; was_req = 0; hold = 0;
        continue;
      end
      if (r_fire) begin r_valid = 1'b0; r_fire = 0; busy = 0; end
      if (m_fire) begin
        m_ready = 1'b0; m_fire = 0; busy = 1; was_req = 0;
        dly = $urandom_range(dly_max, dly_min);
      end
      if (busy) begin
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL m_valid_in_wait: got %b want 0", m_valid); end
        if (!r_valid) begin
          if (dly == 0) begin r_valid = 1'b1; r_data = res; end
          else dly--;
        end
      end else begin
        checks++;
        if (r_ready !== 1'b0) begin failures++; $display("FAIL r_ready_outside_wait: got %b want 0", r_ready); end
        r_valid = spur_en ? 1'($urandom_range(1, 0)) : 1'b0;
        r_data  = 8'hA5;
        if (was_req && m_valid !== 1'b1) begin
          checks++; failures++;
          $display("FAIL m_valid_dropped: got %b want 1", m_valid);
          was_req = 0;
        end
        if (m_valid === 1'b1) begin
          if (was_req) begin
            checks++;
            if (m_a !== hold_a || m_b !== hold_b) begin
              failures++;
              $display("FAIL operand_stable: got a=%0d b=%0d want a=%0d b=%0d", m_a, m_b, hold_a, hold_b);
            end
          end
          was_req = 1; hold_a = m_a; hold_b = m_b;
          if (hold >= hold_cycles) m_ready = 1'b1;
          else hold++;
          if (m_ready) begin
            m_fire = 1; hold = 0; r_valid = 1'b0;
            log_a.push_back(m_a); log_b.push_back(m_b); log_m.push_back(m_modulus);
            res = mont(m_a, m_b, m_modulus);
          end
        end
      end
      if (r_valid && r_ready) r_fire = 1;
    end
  end

  // Runs one job, checks job sequence against a square-and-multiply model, holds o_ready low oready_low cycles.
  task automatic run_job(input logic [MW-1:0] b, input logic [MW-1:0] one, input logic [MW-1:0] n,
                         input logic [EW-1:0] e, input int oready_low, input string tag,
                         output logic [MW-1:0] res);
    logic [MW-1:0] ea[$], eb[$];
    logic [MW-1:0] acc, bb;
    int t;
    acc = one; bb = b;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin ea.push_back(acc); eb.push_back(bb); acc = mont(acc, bb, n); end
      if (i < EW - 1) begin ea.push_back(bb); eb.push_back(bb); bb = mont(bb, bb, n); end
    end
    t = 0;
    while (i_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("FAIL %s_i_ready_wait: got %b want 1", tag, i_ready); end
    log_a.delete(); log_b.delete(); log_m.delete();
    o_ready = (oready_low == 0);
    i_valid = 1'b1; i_base = b; i_one = one; i_modulus = n; i_exponent = e;
    @(negedge clk);
    i_valid = 1'b0;
    t = 0;
    while (o_valid !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (o_valid !== 1'b1) begin failures++; $display("FAIL %s_o_valid_timeout: got %b want 1", tag, o_valid); end
    res = o_result;
    for (int k = 0; k < oready_low; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_result !== res) begin
        failures++;
        $display("FAIL %s_result_stable: got v=%b r=%0d want v=1 r=%0d", tag, o_valid, o_result, res);
      end
    end
    o_ready = 1'b1;
    checks++;
    if (i_ready !== 1'b0) begin failures++; $display("FAIL %s_i_ready_in_done: got %b want 0", tag, i_ready); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_return_idle: got o_valid=%b i_ready=%b want 0 1", tag, o_valid, i_ready);
    end
    checks++;
    if (res !== acc) begin failures++; $display("FAIL %s_model_result: got %0d want %0d", tag, res, acc); end
    checks++;
    if (log_a.size() != ea.size()) begin
      failures++; $display("FAIL %s_job_count: got %0d want %0d", tag, log_a.size(), ea.size());
    end
    for (int i = 0; i < log_a.size() && i < ea.size(); i++) begin
      checks++;
      if (log_a[i] !== ea[i] || log_b[i] !== eb[i] || log_m[i] !== n) begin
        failures++;
        $display("FAIL %s_job%0d: got a=%0d b=%0d n=%0d want a=%0d b=%0d n=%0d",
                 tag, i, log_a[i], log_b[i], log_m[i], ea[i], eb[i], n);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (i_ready !== 1'b1 || m_valid !== 1'b0 || r_ready !== 1'b0 || o_valid !== 1'b0 ||
        o_result !== '0 || m_a !== '0 || m_b !== '0 || m_modulus !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got i_ready=%b m_valid=%b r_ready=%b o_valid=%b o_result=%0d m_a=%0d m_b=%0d m_mod=%0d want 1 0 0 0 0 0 0 0",
               i_ready, m_valid, r_ready, o_valid, o_result, m_a, m_b, m_modulus);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_functional();
    logic [MW-1:0] res;
    hold_cycles = 0; dly_min = 0; dly_max = 0;
    run_job(8'd5, 8'd9, 8'd13, 4'b1011, 0, "func", res);
    checks++;
    if (res !== 8'd11) begin failures++; $display("FAIL func_result: got %0d want 11", res); end
    checks++;
    if (log_a.size() != 6) begin failures++; $display("FAIL func_jobs: got %0d want 6", log_a.size()); end
  endtask

  task automatic test_exponent_edges();
    logic [MW-1:0] res;
    run_job(8'd5, 8'd9, 8'd13, 4'b0000, 0, "exp0", res);
    checks++;
    if (res !== 8'd9 || log_a.size() != 3) begin
      failures++; $display("FAIL exp0: got res=%0d jobs=%0d want 9 3", res, log_a.size());
    end
    run_job(8'd5, 8'd9, 8'd13, 4'b1000, 0, "exp8", res);
    checks++;
    if (res !== 8'd3 || log_a.size() != 4) begin
      failures++; $display("FAIL exp8: got res=%0d jobs=%0d want 3 4", res, log_a.size());
    end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] res;
    hold_cycles = 5; dly_min = 0; dly_max = 7;
    run_job(8'd5, 8'd9, 8'd13, 4'b1011, 4, "bp", res);
    checks++;
    if (res !== 8'd11) begin failures++; $display("FAIL bp_result: got %0d want 11", res); end
    hold_cycles = 0; dly_min = 0; dly_max = 0;
  endtask

  task automatic test_protocol();
    logic [MW-1:0] res;
    spur_en = 1'b1; dly_max = 2;
    fork
      run_job(8'd5, 8'd9, 8'd13, 4'b1011, 3, "proto", res);
      begin
        repeat (6) @(negedge clk);
        i_valid = 1'b1; i_base = 8'd7; i_exponent = 4'b0110; i_one = 8'd1; i_modulus = 8'd11;
        checks++;
        if (i_ready !== 1'b0) begin failures++; $display("FAIL proto_i_ready_busy: got %b want 0", i_ready); end
        @(negedge clk);
        i_valid = 1'b0;
      end
    join
    checks++;
    if (res !== 8'd11) begin failures++; $display("FAIL proto_result: got %0d want 11", res); end
    spur_en = 1'b0; dly_max = 0;
  endtask

  task automatic test_reset_mid_op();
    logic [MW-1:0] res;
    int t;
    dly_min = 6; dly_max = 6;
    log_a.delete(); log_b.delete(); log_m.delete();
    i_valid = 1'b1; i_base = 8'd5; i_one = 8'd9; i_modulus = 8'd13; i_exponent = 4'b1011;
    @(negedge clk);
    i_valid = 1'b0;
    t = 0;
    while (!(log_a.size() == 4 && r_ready === 1'b1) && t < 500) begin @(negedge clk); t++; end
    checks++;
    if (log_a.size() != 4 || r_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_reach_wait_sqr: got jobs=%0d r_ready=%b want 4 1", log_a.size(), r_ready);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (i_ready !== 1'b1 || m_valid !== 1'b0 || r_ready !== 1'b0 || o_valid !== 1'b0 ||
        o_result !== '0 || m_a !== '0 || m_b !== '0 || m_modulus !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got i_ready=%b m_valid=%b r_ready=%b o_valid=%b o_result=%0d m_a=%0d m_b=%0d m_mod=%0d want 1 0 0 0 0 0 0 0",
               i_ready, m_valid, r_ready, o_valid, o_result, m_a, m_b, m_modulus);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    dly_min = 0; dly_max = 3;
    run_job(8'd5, 8'd9, 8'd13, 4'b1011, 0, "rstmid", res);
    checks++;
    if (res !== 8'd11) begin failures++; $display("FAIL rstmid_result: got %0d want 11", res); end
    dly_max = 0;
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] r1, r2;
    o_ready = 1'b1;
    run_job(8'd5, 8'd9, 8'd13, 4'b1011, 0, "b2b1", r1);
    run_job(8'd5, 8'd9, 8'd13, 4'b0101, 0, "b2b2", r2);
    checks++;
    if (r1 !== 8'd11 || r2 !== 8'd2) begin
      failures++; $display("FAIL b2b_results: got %0d %0d want 11 2", r1, r2);
    end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_exponent_edges();
    test_backpressure();
    test_protocol();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsa_mont_exp_ctrl.md
Name: rsa_mont_exp_ctrl

Overview:
Square-and-multiply sequencer computing base^exponent mod N in the Montgomery domain by issuing MUL and SQR jobs to one shared Montgomery multiplier.
Sits between the RSA top-level (operands in, result out) and the multiplier's valid/ready request/response ports.
Operands arrive already in Montgomery form; the result leaves in Montgomery form. Domain conversion is outside this block.

Parameters:
MOD_WIDTH, 256, width of modulus, base, one and result.
EXP_WIDTH, 256, width of exponent; exponent scanned LSB-first, all EXP_WIDTH bits.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
i_valid  in  1  job request.
i_ready  out  1  high only in IDLE.
i_base  in  MOD_WIDTH  base in Montgomery form (x*R mod N).
i_exponent  in  EXP_WIDTH  exponent.
i_modulus  in  MOD_WIDTH  modulus N, odd.
i_one  in  MOD_WIDTH  R mod N (Montgomery 1).
m_valid  out  1  multiplier request valid.
m_ready  in  1  multiplier accepts request.
m_a, m_b, m_modulus  out  MOD_WIDTH each  multiplier operands.
r_valid  in  1  multiplier result valid.
r_ready  out  1  high only in WAIT_MUL/WAIT_SQR.
r_data  in  MOD_WIDTH  multiplier result a*b*R^-1 mod N.
o_valid  out  1  result valid.
o_ready  in  1  consumer accepts result.
o_result  out  MOD_WIDTH  exponentiation result, Montgomery form.

Behaviour:
- Registers: acc, base, exp, mod, bit counter cnt (0..EXP_WIDTH-1), state.
- Reset (async, any state): state=IDLE; all registers 0; i_ready=1, m_valid=0, r_ready=0, o_valid=0, o_result=0, m_a/m_b/m_modulus=0. An in-flight multiplier job is abandoned; the multiplier is reset by the same rst.
- States: IDLE, ISSUE_MUL, WAIT_MUL, ISSUE_SQR, WAIT_SQR, DONE.
- IDLE: on i_valid, latch acc=i_one, base=i_base, exp=i_exponent, mod=i_modulus, cnt=0. Next state is ISSUE_MUL if i_exponent[0]=1, else ISSUE_SQR (or DONE if EXP_WIDTH=1).
- ISSUE_MUL: m_valid=1, m_a=acc, m_b=base. On m_valid&&m_ready go to WAIT_MUL.
- WAIT_MUL: on r_valid, acc<=r_data. Then go to ISSUE_SQR if cnt<EXP_WIDTH-1, else DONE.
- ISSUE_SQR: m_valid=1, m_a=base, m_b=base. On handshake go to WAIT_SQR.
- WAIT_SQR: on r_valid, base<=r_data and cnt<=cnt+1. Next state is ISSUE_MUL if exp[cnt+1]=1, else ISSUE_SQR if cnt+1<EXP_WIDTH-1, else DONE.
- When bit cnt=EXP_WIDTH-1 is 0, the block goes straight from the last square to DONE.
- No square is issued after the last bit. Job count = popcount(exp) + (EXP_WIDTH-1).
- m_modulus=mod whenever m_valid=1.
- m_valid and m_a/m_b/m_modulus stay stable from assertion until the handshake. m_valid never drops without m_ready.
- At most one multiplier job is outstanding. m_valid=0 in WAIT states.
- r_valid outside WAIT states is not accepted (r_ready=0) and has no effect.
- DONE: o_valid=1, o_result=acc, stable until o_ready. On o_valid&&o_ready go to IDLE; i_ready rises the next cycle (no same-cycle back-to-back).
- i_valid outside IDLE is ignored. The input payload is sampled only on the IDLE handshake; later input changes do not affect a running job.
- Exponent 0: result = i_one after EXP_WIDTH-1 squares.
- Latency, zero-wait multiplier of latency L: 2 cycles per job plus L per job, plus 1 cycle IDLE->first issue; deterministic.

Test Plan:
1. Functional, MOD_WIDTH=8, EXP_WIDTH=4, golden multiplier model (R=256): N=13, i_one=9, i_base=5 (x=2), exp=4'b1011 -> o_result=11 (2^11 mod 13 = 7, Montgomery form); exactly 6 jobs in order MUL,SQR,MUL,SQR,SQR,MUL.
2. Same config, exp=0 -> 3 SQR jobs, 0 MUL, o_result=9. exp=4'b1000 -> SQR,SQR,SQR,MUL, o_result = Montgomery form of 2^8 mod 13 = 9*9 mod 13 = 3.
3. Backpressure: m_ready held low 5 cycles on each request, r_valid delayed 0-7 random cycles, o_ready low 4 cycles -> operands and o_result stable throughout; same results as test 1.
4. Protocol: spurious r_valid pulses while in ISSUE/DONE, and i_valid with changed payload mid-job -> r_ready=0 and no state change; result unchanged (11).
5. Reset mid-op: assert rst during WAIT_SQR of the 2nd bit -> all outputs 0 and i_ready=1 immediately (async). A new job after release gives the correct result.
6. Back-to-back: two jobs with o_ready tied high -> i_ready returns 1 the cycle after each o_valid handshake; both results correct.
